// File: rtl/regfile_mp_scoreboard_if.sv
// Bus bundle for the multi-port register file: read ports, write ports,
// scoreboard issue port and the registered busy count.
interface regfile_mp_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int KEYW = $clog2(NREGS);

  logic [NRD*KEYW-1:0] rd_key;
  logic [NRD*XLEN-1:0] rd_value;
  logic [NRD-1:0]      rd_busy;

  logic [NWR-1:0]      wr_enable;
  logic [NWR*KEYW-1:0] wr_key;
  logic [NWR*XLEN-1:0] wr_value;

  logic                sb_set_enable;
  logic [KEYW-1:0]     sb_set_key;

  logic [KEYW:0]       busy_count;

  modport master (
    output rd_key, wr_enable, wr_key, wr_value, sb_set_enable, sb_set_key,
    input  rd_value, rd_busy, busy_count
  );

  modport slave (
    input  rd_key, wr_enable, wr_key, wr_value, sb_set_enable, sb_set_key,
    output rd_value, rd_busy, busy_count
  );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with write-to-read bypass and a per-register
// busy scoreboard (issue sets, writeback clears). Register 0 reads as zero.
module regfile_mp_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter bit BYPASS = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_mp_scoreboard_if.slave  bus
);
  localparam int KEYW = $clog2(NREGS);

  logic [XLEN-1:0]     reg_q [NREGS];
  logic [NREGS-1:0]    busy;
  logic [KEYW:0]       busy_count;

  logic [NREGS-1:0]    wr_hit;
  logic [XLEN-1:0]     wr_data [NREGS];
  logic [NREGS-1:0]    busy_next;
  logic [KEYW:0]       count_next;

  logic [NRD*XLEN-1:0] rd_value;
  logic [NRD-1:0]      rd_busy;

  // Resolve all write ports per register; the ascending scan lets the
  // highest-index port overwrite lower ones on a key conflict.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NREGS; r++) wr_data[r] = '0;
    for (int w = 0; w < NWR; w++) begin
      for (int r = 1; r < NREGS; r++) begin
        if (bus.wr_enable[w] && bus.wr_key[w*KEYW +: KEYW] == KEYW'(r)) begin
          wr_hit[r]  = 1'b1;
          wr_data[r] = bus.wr_value[w*XLEN +: XLEN];
        end
      end
    end
  end

  // Writeback clears, then issue sets, so a same-cycle set wins.
  always_comb begin
    busy_next = busy & ~wr_hit;
    if (bus.sb_set_enable && bus.sb_set_key != '0) busy_next[bus.sb_set_key] = 1'b1;
    busy_next[0] = 1'b0;
    count_next = '0;
    for (int r = 0; r < NREGS; r++) count_next = count_next + {{KEYW{1'b0}}, busy_next[r]};
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign reg_q[r] = '0;
    end else begin : g_live
      logic [XLEN-1:0] q;
      // NOTE: the array lives in resettable flops rather than a RAM macro because
      // reset must clear every register, so no read can ever return X afterwards.
      always_ff @(posedge clk) begin
        if (reset)          q <= '0;
        else if (wr_hit[r]) q <= wr_data[r];
      end
      assign reg_q[r] = q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= count_next;
    end
  end

  // Reads: key 0 and reset force zero; a bypassed write also masks busy,
  // since the consumer receives the producer's value this cycle.
  always_comb begin
    rd_value = '0;
    rd_busy  = '0;
    for (int p = 0; p < NRD; p++) begin
      if (!reset && bus.rd_key[p*KEYW +: KEYW] != '0) begin
        if (BYPASS && wr_hit[bus.rd_key[p*KEYW +: KEYW]]) begin
          rd_value[p*XLEN +: XLEN] = wr_data[bus.rd_key[p*KEYW +: KEYW]];
        end else begin
          rd_value[p*XLEN +: XLEN] = reg_q[bus.rd_key[p*KEYW +: KEYW]];
          rd_busy[p]               = busy[bus.rd_key[p*KEYW +: KEYW]];
        end
      end
    end
  end

  assign bus.rd_value   = rd_value;
  assign bus.rd_busy    = rd_busy;
  assign bus.busy_count = busy_count;
endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Scoreboard bench: two register files (bypass on / off) share one stimulus
// stream; expectations are queued at issue and compared by a negedge monitor.
module tb_regfile_mp_scoreboard;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int KEYW  = $clog2(NREGS);

  typedef struct {
    string                     tag;
    logic [NRD-1:0][XLEN-1:0]  val_a;
    logic [NRD-1:0][XLEN-1:0]  val_b;
    logic [NRD-1:0]            bsy_a;
    logic [NRD-1:0]            bsy_b;
    int                        count;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_mp_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus_a ();
  regfile_mp_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus_b ();

  regfile_mp_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1'b1))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  regfile_mp_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1'b0))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  // Reference model: architectural contents and pending-producer flags.
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  bit              m_known = 1'b0;

  // Current stimulus for the next cycle.
  bit              s_rst;
  bit              s_we [NWR];
  int              s_wk [NWR];
  logic [XLEN-1:0] s_wv [NWR];
  bit              s_se;
  int              s_sk;
  int              s_rk [NRD];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    s_rst = 1'b0;
    s_se  = 1'b0;
    s_sk  = 0;
    for (int w = 0; w < NWR; w++) begin
      s_we[w] = 1'b0; s_wk[w] = 0; s_wv[w] = '0;
    end
    for (int p = 0; p < NRD; p++) s_rk[p] = 0;
  endtask

  task automatic drive_pins();
    reset = s_rst;
    for (int w = 0; w < NWR; w++) begin
      bus_a.wr_enable[w] = s_we[w];             bus_b.wr_enable[w] = s_we[w];
      bus_a.wr_key[w*KEYW +: KEYW] = KEYW'(s_wk[w]); bus_b.wr_key[w*KEYW +: KEYW] = KEYW'(s_wk[w]);
      bus_a.wr_value[w*XLEN +: XLEN] = s_wv[w]; bus_b.wr_value[w*XLEN +: XLEN] = s_wv[w];
    end
    for (int p = 0; p < NRD; p++) begin
      bus_a.rd_key[p*KEYW +: KEYW] = KEYW'(s_rk[p]);
      bus_b.rd_key[p*KEYW +: KEYW] = KEYW'(s_rk[p]);
    end
    bus_a.sb_set_enable = s_se; bus_b.sb_set_enable = s_se;
    bus_a.sb_set_key = KEYW'(s_sk); bus_b.sb_set_key = KEYW'(s_sk);
  endtask

  // What a read of key k returns this cycle, with or without forwarding.
  task automatic model_read(input bit byp, input int k, output logic [XLEN-1:0] v, output bit b);
    int hit_port = -1;
    for (int w = 0; w < NWR; w++) if (s_we[w] && s_wk[w] == k) hit_port = w;
    v = '0;
    b = 1'b0;
    if (s_rst || k == 0) return;
    if (byp && hit_port >= 0) begin
      v = s_wv[hit_port];
    end else begin
      v = m_regs[k];
      b = m_busy[k];
    end
  endtask

  task automatic model_edge();
    if (s_rst) begin
      foreach (m_regs[i]) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
      m_known = 1'b1;
      return;
    end
    for (int w = 0; w < NWR; w++) begin
      if (s_we[w] && s_wk[w] != 0) begin
        m_regs[s_wk[w]] = s_wv[w];
        m_busy[s_wk[w]] = 1'b0;
      end
    end
    if (s_se && s_sk != 0) m_busy[s_sk] = 1'b1;
  endtask

  task automatic step(input string tag);
    exp_t e;
    logic [XLEN-1:0] v;
    bit b;
    int c = 0;
    @(posedge clk);
    #1;
    drive_pins();
    e.tag = tag;
    for (int p = 0; p < NRD; p++) begin
      model_read(1'b1, s_rk[p], v, b); e.val_a[p] = v; e.bsy_a[p] = b;
      model_read(1'b0, s_rk[p], v, b); e.val_b[p] = v; e.bsy_b[p] = b;
    end
    foreach (m_busy[i]) c += int'(m_busy[i]);
    e.count = m_known ? c : -1;
    exp_q.push_back(e);
    model_edge();
  endtask

  function automatic int rand_key();
    return ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, NREGS-1));
  endfunction

  // Monitor: outputs are settled mid-cycle, so compare at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int p = 0; p < NRD; p++) begin
          check($sformatf("%s a_val%0d", e.tag, p), 64'(bus_a.rd_value[p*XLEN +: XLEN]), 64'(e.val_a[p]));
          check($sformatf("%s b_val%0d", e.tag, p), 64'(bus_b.rd_value[p*XLEN +: XLEN]), 64'(e.val_b[p]));
          check($sformatf("%s a_busy%0d", e.tag, p), 64'(bus_a.rd_busy[p]), 64'(e.bsy_a[p]));
          check($sformatf("%s b_busy%0d", e.tag, p), 64'(bus_b.rd_busy[p]), 64'(e.bsy_b[p]));
        end
        if (e.count >= 0) begin
          check({e.tag, " a_count"}, 64'(bus_a.busy_count), 64'(e.count));
          check({e.tag, " b_count"}, 64'(bus_b.busy_count), 64'(e.count));
        end
      end
    end
  end

  initial begin
    foreach (m_regs[i]) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
    idle_inputs();
    s_rst = 1'b1;
    drive_pins();

    idle_inputs(); s_rst = 1'b1; s_rk[0] = 3; s_rk[1] = 4; step("reset");
    for (int i = 1; i < NREGS; i++) begin
      idle_inputs(); s_rk[0] = i; s_rk[1] = NREGS - i; step("post_reset_read");
    end

    idle_inputs();
    s_we[0] = 1; s_wk[0] = 5; s_wv[0] = 32'hDEADBEEF;
    s_we[1] = 1; s_wk[1] = 0; s_wv[1] = 32'h12345678;
    s_rk[0] = 5; s_rk[1] = 0; step("wr5_x0");
    idle_inputs(); s_rk[0] = 5; s_rk[1] = 0; step("rd5_x0");

    idle_inputs(); s_we[0] = 1; s_wk[0] = 7; s_wv[0] = 32'hA5A5A5A5;
    s_rk[0] = 7; s_rk[1] = 7; step("bypass7");
    idle_inputs(); s_rk[0] = 7; s_rk[1] = 5; step("rd7");

    idle_inputs();
    s_we[0] = 1; s_wk[0] = 3; s_wv[0] = 32'h1;
    s_we[1] = 1; s_wk[1] = 3; s_wv[1] = 32'h2;
    s_rk[0] = 3; s_rk[1] = 3; step("conflict3");
    idle_inputs(); s_rk[0] = 3; step("rd3");

    idle_inputs(); s_se = 1; s_sk = 9; s_rk[0] = 9; step("set9");
    idle_inputs(); s_rk[0] = 9; s_rk[1] = 9; step("busy9");
    idle_inputs(); s_we[0] = 1; s_wk[0] = 9; s_wv[0] = 32'h99; s_rk[0] = 9; step("wb9");
    idle_inputs(); s_rk[0] = 9; step("cleared9");
    idle_inputs(); s_se = 1; s_sk = 9; s_we[1] = 1; s_wk[1] = 9; s_wv[1] = 32'h999;
    s_rk[1] = 9; step("set_wb9");
    idle_inputs(); s_rk[0] = 9; step("still_busy9");
    idle_inputs(); s_se = 1; s_sk = 9; s_rk[0] = 9; step("reset9_again");
    idle_inputs(); s_se = 1; s_sk = 0; s_rk[0] = 0; step("set0");
    idle_inputs(); s_rk[0] = 9; s_rk[1] = 0; step("after_set0");

    idle_inputs(); s_we[0] = 1; s_wk[0] = 4; s_wv[0] = 32'hFF; s_se = 1; s_sk = 4; step("wr4_set4");
    idle_inputs(); s_se = 1; s_sk = 6; s_rk[0] = 4; s_rk[1] = 6; step("set6");
    idle_inputs(); s_rst = 1; s_we[0] = 1; s_wk[0] = 6; s_wv[0] = 32'h66;
    s_rk[0] = 4; s_rk[1] = 6; step("mid_reset");
    idle_inputs(); s_rk[0] = 4; s_rk[1] = 6; step("after_reset");

    for (int n = 0; n < 400; n++) begin
      idle_inputs();
      s_rst = ($urandom_range(0, 49) == 0);
      for (int w = 0; w < NWR; w++) begin
        s_we[w] = ($urandom_range(0, 2) != 0);
        s_wk[w] = rand_key();
        s_wv[w] = $urandom;
      end
      s_se = ($urandom_range(0, 1) == 1);
      s_sk = rand_key();
      for (int p = 0; p < NRD; p++) s_rk[p] = rand_key();
      step("random");
    end

    idle_inputs();
    step("tail");
    repeat (3) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
